// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : button_event_decoder
// Purpose  : Classifies debounced press/release pulses into click gestures.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_decoder #(
    parameter int TICK_DIV  = 100000,
    parameter int LONG_MS   = 1000,
    parameter int DOUBLE_MS = 300,
    parameter int REPEAT_MS = 200
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_pe,
    input  logic btn_ne,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic pressed
);

    localparam int              c_PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST    = c_PW'(TICK_DIV - 1);
    localparam logic [11:0]     c_LONG_LAST   = 12'(LONG_MS - 1);
    localparam logic [11:0]     c_DOUBLE_LAST = 12'(DOUBLE_MS - 1);
    localparam logic [11:0]     c_REPEAT_LAST = 12'(REPEAT_MS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS1    = 3'd1,
        S_WAIT2     = 3'd2,
        S_PRESS2    = 3'd3,
        S_LONG_HOLD = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [c_PW-1:0] r_pre;
    logic [11:0]     r_ms;
    logic            r_short, r_double, r_long, r_repeat, r_pressed;
    logic            w_short, w_double, w_long, w_repeat, w_restart;
    logic            w_pe, w_ne, w_tick_last, w_long_hit, w_double_hit, w_repeat_hit, w_clear;

    // Simultaneous press and release pulses cancel each other out.
    assign w_pe         = btn_pe & ~btn_ne;
    assign w_ne         = btn_ne & ~btn_pe;
    assign w_tick_last  = (r_pre == c_PRE_LAST);
    assign w_long_hit   = w_tick_last && (r_ms == c_LONG_LAST);
    assign w_double_hit = w_tick_last && (r_ms == c_DOUBLE_LAST);
    assign w_repeat_hit = w_tick_last && (r_ms == c_REPEAT_LAST);

    // Edges are tested before timer hits so an edge always wins a tie.
    always_comb begin
        w_next    = r_state;
        w_short   = 1'b0;
        w_double  = 1'b0;
        w_long    = 1'b0;
        w_repeat  = 1'b0;
        w_restart = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pe) w_next = S_PRESS1;
            end
            S_PRESS1: begin
                if (w_ne) begin
                    w_next = S_WAIT2;
                end else if (w_long_hit) begin
                    w_next = S_LONG_HOLD;
                    w_long = 1'b1;
                end
            end
            S_WAIT2: begin
                if (w_pe) begin
                    w_next = S_PRESS2;
                end else if (w_double_hit) begin
                    w_next  = S_IDLE;
                    w_short = 1'b1;
                end
            end
            S_PRESS2: begin
                if (w_ne) begin
                    w_next   = S_IDLE;
                    w_double = 1'b1;
                end else if (w_long_hit) begin
                    w_next = S_LONG_HOLD;
                    w_long = 1'b1;
                end
            end
            S_LONG_HOLD: begin
                if (w_ne) begin
                    w_next = S_IDLE;
                end else if (w_repeat_hit) begin
                    w_repeat  = 1'b1;
                    w_restart = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_clear = (w_next != r_state) || w_restart || (r_state == S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_pre     <= '0;
            r_ms      <= '0;
            r_short   <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_pressed <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_short   <= w_short;
            r_double  <= w_double;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_pressed <= (w_next == S_PRESS1) || (w_next == S_PRESS2) ||
                         (w_next == S_LONG_HOLD);
            if (w_clear) begin
                r_pre <= '0;
                r_ms  <= '0;
            end else if (w_tick_last) begin
                r_pre <= '0;
                r_ms  <= r_ms + 12'd1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign short_press  = r_short;
    assign double_click = r_double;
    assign long_press   = r_long;
    assign repeat_pulse = r_repeat;
    assign pressed      = r_pressed;

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_decoder
// Purpose  : Self-checking bench: gesture-level model plus directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;

    localparam int TICK_DIV  = 10;
    localparam int LONG_MS   = 20;
    localparam int DOUBLE_MS = 8;
    localparam int REPEAT_MS = 5;
    localparam int LONG_T    = LONG_MS * TICK_DIV;
    localparam int DBL_T     = DOUBLE_MS * TICK_DIV;
    localparam int REP_T     = REPEAT_MS * TICK_DIV;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic btn_pe = 1'b0;
    logic btn_ne = 1'b0;
    logic short_press, double_click, long_press, repeat_pulse, pressed;

    int n_tests = 0;
    int n_fail  = 0;

    button_event_decoder #(
        .TICK_DIV (TICK_DIV),
        .LONG_MS  (LONG_MS),
        .DOUBLE_MS(DOUBLE_MS),
        .REPEAT_MS(REPEAT_MS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_pe      (btn_pe),
        .btn_ne      (btn_ne),
        .short_press (short_press),
        .double_click(double_click),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .pressed     (pressed)
    );

    always #5 clk = ~clk;

    // Output vector layout: {pressed, repeat, long, double, short}
    logic [4:0] dut_vec;
    assign dut_vec = {pressed, repeat_pulse, long_press, double_click, short_press};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Gesture model: phase 0 released, 1 first hold, 2 gap after first click,
    // 3 second hold, 4 long hold. Time is tracked as cycles since phase start.
    int         m_phase = 0;
    int         m_start = 0;
    int         m_now   = 0;
    logic [4:0] m_out   = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0;
            m_start = 0;
            m_now   = 0;
            m_out   = '0;
        end else begin
            bit         pe, ne;
            int         age, nphase;
            logic [3:0] pul;
            pe     = btn_pe && !btn_ne;
            ne     = btn_ne && !btn_pe;
            age    = m_now - m_start;
            nphase = m_phase;
            pul    = 4'b0000;
            case (m_phase)
                0: if (pe) nphase = 1;
                1: if (ne) nphase = 2;
                   else if (age == LONG_T - 1) begin nphase = 4; pul = 4'b0100; end
                2: if (pe) nphase = 3;
                   else if (age == DBL_T - 1) begin nphase = 0; pul = 4'b0001; end
                3: if (ne) begin nphase = 0; pul = 4'b0010; end
                   else if (age == LONG_T - 1) begin nphase = 4; pul = 4'b0100; end
                4: if (ne) nphase = 0;
                   else if (age == REP_T - 1) begin pul = 4'b1000; m_start = m_now + 1; end
                default: nphase = 0;
            endcase
            if (nphase != m_phase) m_start = m_now + 1;
            m_phase = nphase;
            m_now++;
            m_out = {(m_phase == 1 || m_phase == 3 || m_phase == 4), pul};
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            check("model", {27'd0, dut_vec}, {27'd0, m_out});
            check("one_pulse", {31'd0, ($countones(dut_vec[3:0]) <= 1)}, 32'd1);
        end
    end

    logic [4:0] log_out [0:511];

    // Drives pulses at scenario cycles (-1 = unused); log_out[c+1] holds the
    // outputs registered from cycle c.
    task automatic run(input int len, input int pe_a, input int pe_b,
                       input int ne_a, input int ne_b);
        for (int i = 0; i < 512; i++) log_out[i] = '0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            btn_pe = (c == pe_a) || (c == pe_b);
            btn_ne = (c == ne_a) || (c == ne_b);
            @(posedge clk);
            #1;
            log_out[c+1] = dut_vec;
        end
        @(negedge clk);
        btn_pe = 1'b0;
        btn_ne = 1'b0;
    endtask

    function automatic int count_bit(input int b, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(log_out[i][b]);
        return n;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {27'd0, dut_vec}, 32'd0);
        reset_n = 1'b1;

        // Short press
        run(200, 0, -1, 50, -1);
        check("sp_pressed_1", log_out[1][4], 1);
        check("sp_pressed_50", log_out[50][4], 1);
        check("sp_pressed_51", log_out[51][4], 0);
        check("sp_short_131", log_out[131][0], 1);
        check("sp_short_cnt", count_bit(0, 1, 200), 1);
        check("sp_other_cnt", count_bit(1, 1, 200) + count_bit(2, 1, 200) + count_bit(3, 1, 200), 0);

        // Double click
        run(200, 0, 100, 50, 150);
        check("dc_double_151", log_out[151][1], 1);
        check("dc_double_cnt", count_bit(1, 1, 200), 1);
        check("dc_short_cnt", count_bit(0, 1, 200), 0);

        // Second press exactly on the gap timeout cycle
        run(250, 0, 130, 50, 180);
        check("wb_double_181", log_out[181][1], 1);
        check("wb_short_cnt", count_bit(0, 1, 250), 0);

        // Second press one cycle late
        run(300, 0, 131, 50, 160);
        check("wl_short_131", log_out[131][0], 1);
        check("wl_pressed_131", log_out[131][4], 0);
        check("wl_pressed_132", log_out[132][4], 1);
        check("wl_short_241", log_out[241][0], 1);
        check("wl_short_cnt", count_bit(0, 1, 300), 2);
        check("wl_double_cnt", count_bit(1, 1, 300), 0);

        // Long press with repeats
        run(450, 0, -1, 400, -1);
        check("lp_long_201", log_out[201][2], 1);
        check("lp_long_cnt", count_bit(2, 1, 450), 1);
        check("lp_rep_251", log_out[251][3], 1);
        check("lp_rep_301", log_out[301][3], 1);
        check("lp_rep_351", log_out[351][3], 1);
        check("lp_rep_401", log_out[401][3], 0);
        check("lp_rep_cnt", count_bit(3, 1, 450), 3);
        check("lp_sd_cnt", count_bit(0, 1, 450) + count_bit(1, 1, 450), 0);
        check("lp_pressed_400", log_out[400][4], 1);
        check("lp_pressed_401", log_out[401][4], 0);

        // Asynchronous reset while in long hold
        run(250, 0, -1, -1, -1);
        check("rs_pressed_before", {31'd0, pressed}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rs_async_outputs", {27'd0, dut_vec}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        run(20, -1, -1, 2, -1);
        check("rs_after_pulses", count_bit(0, 1, 20) + count_bit(1, 1, 20) +
                                 count_bit(2, 1, 20) + count_bit(3, 1, 20), 0);
        check("rs_after_pressed", count_bit(4, 1, 20), 0);

        // Simultaneous edges and lone release in idle
        run(30, 3, -1, 3, 10);
        check("ig_pressed_cnt", count_bit(4, 1, 30), 0);
        check("ig_pulse_cnt", count_bit(0, 1, 30) + count_bit(1, 1, 30) +
                              count_bit(2, 1, 30) + count_bit(3, 1, 30), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
